midi_receiver: RTL and testbench
================================

MIDI_RECEIVER -- requirements
Module: midi_receiver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31_250, meaning the MIDI serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1  MIDI serial data; asynchronous to clk; idle high.
REQ-006 SHALL have port note  output  MIDI::bits (7)  key number of the last accepted Note On.
REQ-007 SHALL have port velocity  output  MIDI::bits (7)  velocity of the last accepted Note On, or 0 after its matching Note Off.
REQ-008 SHALL have port update  output  1  single-cycle pulse whenever note or velocity is written.
REQ-009 SHALL have port frameErr  output  1  single-cycle pulse on a stop-bit error.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer before any use; the synchronized level is called rxS below.
REQ-011 SHALL derive the bit period BIT = CLK_HZ/BAUD clocks (320 at the defaults), counted by a bit-period counter.
REQ-012 SHALL run the byte receiver FSM with states IDLE, START, DATA, STOP.
- IDLE: waits for rxS = 0.
- START: samples at BIT/2; rxS = 1 there means a glitch and returns to IDLE; otherwise moves to DATA.
- DATA: samples 8 bits LSB-first at each full BIT interval.
- STOP: samples once more.
REQ-013 SHALL, when rxS = 1 at the STOP sample, deliver the byte to the parser with a one-cycle strobe and return to IDLE.
REQ-014 SHALL, when rxS = 0 at the STOP sample, discard the byte, pulse frameErr, leave the parser state unchanged and stay in STOP until rxS = 1.
REQ-015 SHALL treat bytes 0xF8-0xFF (real-time) as transparent: ignored, with running status and the data-byte position preserved.
REQ-016 SHALL, on a status byte 0x80-0xEF, latch it as running status and reset the data-byte position to first.
REQ-017 SHALL, on a status byte 0xF0-0xF7, clear running status; data bytes are then ignored until the next channel status byte.
REQ-018 SHALL, on a data byte (bit7 = 0) with running status valid, store it as the first or second data byte.
- Types 0xC and 0xD take 1 data byte; all other types take 2.
- When the required count is reached, the message completes and the position resets to first (running status retained).
REQ-019 SHALL accept all 16 channels (omni).
REQ-020 SHALL, on completion of a type 0x9 message with d2 != 0, set note <= d1 and velocity <= d2 and pulse update.
REQ-021 SHALL, on completion of type 0x8, or type 0x9 with d2 = 0, where d1 == note, set velocity <= 0 (note held) and pulse update; when d1 != note, change no output.
REQ-022 SHALL make outputs and update valid on the clock edge after the stop-bit sample of the completing byte (1-cycle latency).
REQ-023 SHALL silently ignore completed messages of all other types.

Reset
REQ-024 SHALL, while rst_n = 0, force note = 0, velocity = 0, update = 0, frameErr = 0, FSM = IDLE, running status invalid and synchronizer flops = 1.
REQ-025 SHALL abandon a byte in progress when reset asserts mid-byte, and after release wait for a new falling edge.

Structure
REQ-026 SHALL take MIDI::bits = 7, the status nibble constants (NOTE_OFF = 4'h8, NOTE_ON = 4'h9) and the baud default from the shared MIDI package.
REQ-027 SHALL implement the bit-level FSM as sub-module midi_uart_rx, which outputs a byte, a byte strobe and frameErr; the parser lives in midi_receiver.

Verification
REQ-028 SHALL cover: 0x90,0x3C,0x64 at 31250 baud -> note = 60, velocity = 100, one update pulse 1 cycle after the final stop sample.
REQ-029 SHALL cover: running status 0x90,0x40,0x50 then 0x45,0x20 -> note = 69, velocity = 32, two update pulses.
REQ-030 SHALL cover: 0x90,0x3C,0x64 then 0x80,0x3C,0x00 -> velocity = 0, note = 60; then 0x90,0x3E,0x00 -> no change, no update.
REQ-031 SHALL cover: 0x90,0x30,0xF8,0x70 (clock byte injected) -> note = 48, velocity = 112.
REQ-032 SHALL cover: a byte with stop bit = 0 -> frameErr pulses once and outputs are unchanged; a 1 us low glitch on rx -> no byte strobe.
REQ-033 SHALL cover: rst_n asserted during the DATA state of 0x3C -> all outputs 0; a subsequent full 0x90,0x24,0x7F -> note = 36, velocity = 127.

Source files
------------

// File: rtl/midi_receiver_pkg.sv
// Shared MIDI definitions: data width, status nibbles, baud default and the
// receiver state/parser types used by midi_uart_rx and midi_receiver.
package midi_receiver_pkg;

  localparam int BITS         = 7;
  localparam int BAUD_DEFAULT = 31_250;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  // Running-status parser state
  typedef struct packed {
    logic            rs_vld;
    logic [3:0]      rs_typ;
    logic            pos;     // 0: expecting first data byte, 1: second
    logic [BITS-1:0] d1;
  } parse_t;

  function automatic logic one_data_byte(input logic [3:0] typ);
    return (typ == PROG_CHG) || (typ == CHAN_PRESS);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// Bit-level MIDI byte receiver: 2-flop synchronizer, mid-bit sampling,
// one-cycle byte strobe and frame-error pulse.
module midi_uart_rx
  import midi_receiver_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       stb,
  output logic       frame_err
);

  localparam int BIT  = CLK_HZ / BAUD;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);

  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  logic          err_wait, err_wait_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end
  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bidx     <= '0;
      shreg    <= '0;
      err_wait <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bidx     <= bidx_n;
      shreg    <= shreg_n;
      err_wait <= err_wait_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    bidx_n     = bidx;
    shreg_n    = shreg;
    err_wait_n = err_wait;
    stb        = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n      = '0;
        bidx_n     = '0;
        err_wait_n = 1'b0;
        if (!rxs) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n   = '0;
          state_n = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == CW'(BIT - 1)) begin
          cnt_n   = '0;
          shreg_n = {rxs, shreg[7:1]};
          bidx_n  = bidx + 3'd1;
          if (bidx == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        // After a bad stop bit, park here until the line returns high
        if (err_wait) begin
          cnt_n = '0;
          if (rxs) begin
            state_n    = ST_IDLE;
            err_wait_n = 1'b0;
          end
        end else if (cnt == CW'(BIT - 1)) begin
          cnt_n = '0;
          if (rxs) begin
            stb     = 1'b1;
            state_n = ST_IDLE;
          end else begin
            frame_err  = 1'b1;
            err_wait_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign data = shreg;

endmodule

// File: rtl/midi_receiver.sv
// MIDI Note On/Off receiver: byte receiver plus running-status parser that
// tracks the last note and its velocity.
module midi_receiver
  import midi_receiver_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = BAUD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic [BITS-1:0] note,
  output logic [BITS-1:0] velocity,
  output logic            update,
  output logic            frameErr
);

  logic [7:0]      rx_data;
  logic            rx_stb;
  logic            rx_ferr;
  parse_t          ps, ps_n;
  logic [BITS-1:0] note_n, vel_n;
  logic            upd_n;
  logic [BITS-1:0] dd2;

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (rx_data),
    .stb       (rx_stb),
    .frame_err (rx_ferr)
  );

  assign dd2 = rx_data[BITS-1:0];

  always_comb begin
    ps_n   = ps;
    note_n = note;
    vel_n  = velocity;
    upd_n  = 1'b0;
    if (rx_stb) begin
      if (rx_data >= 8'hF8) begin
        // real-time bytes are invisible to the parser
      end else if (rx_data[7]) begin
        ps_n.rs_vld = (rx_data < 8'hF0);
        ps_n.rs_typ = rx_data[7:4];
        ps_n.pos    = 1'b0;
      end else if (ps.rs_vld) begin
        if (!ps.pos && !one_data_byte(ps.rs_typ)) begin
          ps_n.d1  = rx_data[BITS-1:0];
          ps_n.pos = 1'b1;
        end else begin
          ps_n.pos = 1'b0;
          // Note On/Off are two-byte types, so d1 is valid in these branches
          if (ps.rs_typ == NOTE_ON && dd2 != '0) begin
            note_n = ps.d1;
            vel_n  = dd2;
            upd_n  = 1'b1;
          end else if ((ps.rs_typ == NOTE_OFF || ps.rs_typ == NOTE_ON) &&
                       ps.d1 == note) begin
            vel_n = '0;
            upd_n = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps       <= '0;
      note     <= '0;
      velocity <= '0;
      update   <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      ps       <= ps_n;
      note     <= note_n;
      velocity <= vel_n;
      update   <= upd_n;
      frameErr <= rx_ferr;
    end
  end

endmodule

// File: tb/tb_midi_receiver.sv
// Self-checking bench for midi_receiver: directed scenarios plus randomized
// message streams compared against a message-level MIDI reference model.
module tb_midi_receiver;

  // 2 MHz clock keeps the run short; the bit period is then 64 clocks
  localparam int CLK_HZ = 2_000_000;
  localparam int BAUD   = 31_250;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [6:0] note, velocity;
  logic       update, frameErr;

  always #250 clk = ~clk;

  midi_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .note     (note),
    .velocity (velocity),
    .update   (update),
    .frameErr (frameErr)
  );

  int checks = 0, errors = 0;
  int cyc = 0, upd_cnt = 0, fe_cnt = 0, stb_cnt = 0, last_upd_cyc = 0;
  int last_stop_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (update) begin upd_cnt++; last_upd_cyc = cyc; end
    if (frameErr) fe_cnt++;
    if (dut.u_rx.stb) stb_cnt++;
  end

  // Reference model: running status, pending data bytes, tracked outputs
  int m_rs = -1, m_pos = 0, m_d1 = 0;
  int m_note = 0, m_vel = 0, m_upd = 0;

  task automatic model_reset();
    m_rs = -1; m_pos = 0; m_note = 0; m_vel = 0;
  endtask

  task automatic model_byte(input int b);
    int need;
    if (b >= 248) return;
    if (b >= 128) begin
      m_rs  = (b < 240) ? (b / 16) : -1;
      m_pos = 0;
      return;
    end
    if (m_rs < 0) return;
    need = (m_rs == 12 || m_rs == 13) ? 1 : 2;
    if (need == 2 && m_pos == 0) begin m_d1 = b; m_pos = 1; return; end
    m_pos = 0;
    if (need == 1) return;
    if (m_rs == 9 && b != 0) begin
      m_note = m_d1; m_vel = b; m_upd++;
    end else if ((m_rs == 8 || m_rs == 9) && m_d1 == m_note) begin
      m_vel = 0; m_upd++;
    end
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_bit, input int extra_low);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    last_stop_cyc = cyc;
    repeat (BIT + extra_low) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send(input int b);
    logic [7:0] v;
    v = b[7:0];
    send_raw(v, 1'b1, 0);
    model_byte(b);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (note !== 7'd0) begin errors++; $display("FAIL reset_note got=%0d exp=0", note); end
    checks++; if (velocity !== 7'd0) begin errors++; $display("FAIL reset_vel got=%0d exp=0", velocity); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update got=%b exp=0", update); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("FAIL reset_frameErr got=%b exp=0", frameErr); end
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_note_on();
    int base;
    base = upd_cnt;
    send(8'h90); send(8'h3C); send(8'h64);
    settle();
    checks++; if (note !== 7'd60) begin errors++; $display("FAIL note_on_note got=%0d exp=60", note); end
    checks++; if (velocity !== 7'd100) begin errors++; $display("FAIL note_on_vel got=%0d exp=100", velocity); end
    checks++; if (upd_cnt - base !== 1) begin errors++; $display("FAIL note_on_updates got=%0d exp=1", upd_cnt - base); end
    // start seen 2 sync flops + 1 FSM edge late; stop sampled HALF in; update 1 edge later
    checks++;
    if (last_upd_cyc !== last_stop_cyc + HALF + 3) begin
      errors++; $display("FAIL note_on_latency got=%0d exp=%0d", last_upd_cyc - last_stop_cyc, HALF + 3);
    end
  endtask

  task automatic test_running_status();
    int base;
    base = upd_cnt;
    send(8'h90); send(8'h40); send(8'h50); send(8'h45); send(8'h20);
    settle();
    checks++; if (note !== 7'd69) begin errors++; $display("FAIL running_note got=%0d exp=69", note); end
    checks++; if (velocity !== 7'd32) begin errors++; $display("FAIL running_vel got=%0d exp=32", velocity); end
    checks++; if (upd_cnt - base !== 2) begin errors++; $display("FAIL running_updates got=%0d exp=2", upd_cnt - base); end
  endtask

  task automatic test_note_off();
    int base;
    base = upd_cnt;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h80); send(8'h3C); send(8'h00);
    settle();
    checks++; if (note !== 7'd60) begin errors++; $display("FAIL off_note got=%0d exp=60", note); end
    checks++; if (velocity !== 7'd0) begin errors++; $display("FAIL off_vel got=%0d exp=0", velocity); end
    checks++; if (upd_cnt - base !== 2) begin errors++; $display("FAIL off_updates got=%0d exp=2", upd_cnt - base); end
    base = upd_cnt;
    send(8'h90); send(8'h3E); send(8'h00);
    settle();
    checks++; if (note !== 7'd60) begin errors++; $display("FAIL off_other_note got=%0d exp=60", note); end
    checks++; if (velocity !== 7'd0) begin errors++; $display("FAIL off_other_vel got=%0d exp=0", velocity); end
    checks++; if (upd_cnt !== base) begin errors++; $display("FAIL off_other_updates got=%0d exp=0", upd_cnt - base); end
  endtask

  task automatic test_realtime();
    int base;
    base = upd_cnt;
    send(8'h90); send(8'h30); send(8'hF8); send(8'h70);
    settle();
    checks++; if (note !== 7'd48) begin errors++; $display("FAIL rt_note got=%0d exp=48", note); end
    checks++; if (velocity !== 7'd112) begin errors++; $display("FAIL rt_vel got=%0d exp=112", velocity); end
    checks++; if (upd_cnt - base !== 1) begin errors++; $display("FAIL rt_updates got=%0d exp=1", upd_cnt - base); end
  endtask

  task automatic test_frame_err();
    int fbase, ubase, sbase;
    fbase = fe_cnt; ubase = upd_cnt;
    // bad stop bit, line held low a further bit time before returning high
    send_raw(8'h55, 1'b0, BIT);
    repeat (BIT) @(negedge clk);
    checks++; if (fe_cnt - fbase !== 1) begin errors++; $display("FAIL frame_pulses got=%0d exp=1", fe_cnt - fbase); end
    checks++; if (upd_cnt !== ubase) begin errors++; $display("FAIL frame_updates got=%0d exp=0", upd_cnt - ubase); end
    checks++; if (note !== 7'd48 || velocity !== 7'd112) begin
      errors++; $display("FAIL frame_outputs got=%0d/%0d exp=48/112", note, velocity);
    end
    // discarded byte must not have become a pending first data byte
    send(8'h45); send(8'h33);
    settle();
    checks++; if (note !== 7'd69 || velocity !== 7'd51) begin
      errors++; $display("FAIL frame_after got=%0d/%0d exp=69/51", note, velocity);
    end
    sbase = stb_cnt; ubase = upd_cnt;
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk); rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++; if (stb_cnt !== sbase) begin errors++; $display("FAIL glitch_strobe got=%0d exp=0", stb_cnt - sbase); end
    checks++; if (upd_cnt !== ubase) begin errors++; $display("FAIL glitch_updates got=%0d exp=0", upd_cnt - ubase); end
  endtask

  task automatic test_reset_mid();
    int ubase;
    logic [7:0] b;
    b = 8'h3C;
    @(negedge clk); rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin rx = b[i]; repeat (BIT) @(negedge clk); end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (note !== 7'd0 || velocity !== 7'd0) begin
      errors++; $display("FAIL midreset_outputs got=%0d/%0d exp=0/0", note, velocity);
    end
    checks++; if (update !== 1'b0 || frameErr !== 1'b0) begin
      errors++; $display("FAIL midreset_pulses got=%b/%b exp=0/0", update, frameErr);
    end
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    // running status is gone, so these data bytes are ignored
    ubase = upd_cnt;
    send(8'h40); send(8'h40);
    settle();
    checks++; if (upd_cnt !== ubase) begin errors++; $display("FAIL midreset_nostatus got=%0d exp=0", upd_cnt - ubase); end
    send(8'h90); send(8'h24); send(8'h7F);
    settle();
    checks++; if (note !== 7'd36) begin errors++; $display("FAIL midreset_note got=%0d exp=36", note); end
    checks++; if (velocity !== 7'd127) begin errors++; $display("FAIL midreset_vel got=%0d exp=127", velocity); end
    checks++; if (upd_cnt - ubase !== 1) begin errors++; $display("FAIL midreset_updates got=%0d exp=1", upd_cnt - ubase); end
  endtask

  task automatic test_random();
    int msg[$];
    int kind, ch;
    for (int it = 0; it < 14; it++) begin
      msg.delete();
      kind = $urandom_range(0, 5);
      ch   = $urandom_range(0, 15);
      case (kind)
        0: begin
          msg.push_back(8'h90 + ch);
          msg.push_back(60 + $urandom_range(0, 2));
          msg.push_back(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127));
        end
        1: begin
          msg.push_back(8'h80 + ch);
          msg.push_back(60 + $urandom_range(0, 2));
          msg.push_back($urandom_range(0, 127));
        end
        2: begin
          msg.push_back(60 + $urandom_range(0, 2));
          msg.push_back($urandom_range(0, 127));
        end
        3: begin
          msg.push_back(8'hC0 + ch);
          msg.push_back($urandom_range(0, 127));
        end
        4: begin
          msg.push_back(8'hF0);
          msg.push_back($urandom_range(0, 127));
          msg.push_back(8'hF7);
        end
        default: begin
          msg.push_back(8'hB0 + ch);
          msg.push_back($urandom_range(0, 127));
          msg.push_back($urandom_range(0, 127));
        end
      endcase
      foreach (msg[k]) begin
        if ($urandom_range(0, 4) == 0) send($urandom_range(8'hF8, 8'hFF));
        send(msg[k]);
      end
      settle();
      checks++; if (note !== m_note[6:0]) begin errors++; $display("FAIL rand%0d_note got=%0d exp=%0d", it, note, m_note); end
      checks++; if (velocity !== m_vel[6:0]) begin errors++; $display("FAIL rand%0d_vel got=%0d exp=%0d", it, velocity, m_vel); end
      checks++; if (upd_cnt !== m_upd) begin errors++; $display("FAIL rand%0d_updates got=%0d exp=%0d", it, upd_cnt, m_upd); end
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_note_off();
    test_realtime();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
